// File: rtl/la_pkg.sv
// Shared definitions for the logic analyzer digital core: SPI trigger states,
// frame lengths and synchronizer reset values.
package la_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RX,
    CHECK
  } spi_trig_state_t;

  localparam int SPI_LEN8  = 8;
  localparam int SPI_LEN16 = 16;

  // Reset values match the idle bus: SS_n deasserted, SCLK and MOSI low.
  localparam logic SYNC_RST_SS   = 1'b1;
  localparam logic SYNC_RST_SCLK = 1'b0;
  localparam logic SYNC_RST_MOSI = 1'b0;

endpackage

// File: rtl/la_sync_edge.sv
// Two-flop synchronizer for an asynchronous input plus a history flop that
// yields single-cycle rise/fall strobes from the synchronized value.
module la_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic meta;
  logic hist;

  // NOTE: non-blocking assignments make the three flops a true shift chain;
  // blocking ones would collapse it into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      sync <= RST_VAL;
      hist <= RST_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      hist <= sync;
    end
  end

  assign rise = sync & ~hist;
  assign fall = ~sync & hist;

endmodule

// File: rtl/spi_prot_trig.sv
// Passive SPI frame decoder that pulses SPItrig when a frame matches match/mask.
// Optional matched-frame counter frm_cnt is built when SPI_TRIG_CNT_EN is defined.
module spi_prot_trig
  import la_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             SS_n,
  input  logic             SCLK,
  input  logic             MOSI,
  input  logic             pos_edge,
  input  logic             len8,
  input  logic [WIDTH-1:0] match,
  input  logic [WIDTH-1:0] mask,
  input  logic             armed,
  output logic             SPItrig
`ifdef SPI_TRIG_CNT_EN
  ,
  output logic [7:0]       frm_cnt
`endif
);

  logic ss_sync, ss_rise, ss_fall;
  logic sclk_sync, sclk_rise, sclk_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  la_sync_edge #(.RST_VAL(SYNC_RST_SS)) u_sync_ss (
    .clk(clk), .rst(rst), .din(SS_n),
    .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
  );

  la_sync_edge #(.RST_VAL(SYNC_RST_SCLK)) u_sync_sclk (
    .clk(clk), .rst(rst), .din(SCLK),
    .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
  );

  la_sync_edge #(.RST_VAL(SYNC_RST_MOSI)) u_sync_mosi (
    .clk(clk), .rst(rst), .din(MOSI),
    .sync(mosi_sync), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{ss_sync, sclk_sync, mosi_rise, mosi_fall};

  spi_trig_state_t  state, state_nxt;
  logic [WIDTH-1:0] shft, shft_nxt;
  logic [4:0]       bit_cnt, cnt_nxt;
  logic             trig_nxt;

  logic             sclk_sel;
  logic             len_ok;
  logic [WIDTH-1:0] lane;
  logic [WIDTH-1:0] diff;
  logic             frame_hit;

  assign sclk_sel = pos_edge ? sclk_rise : sclk_fall;

  // Exact bit count rejects both short and over-length frames.
  assign len_ok    = (bit_cnt == (len8 ? 5'(SPI_LEN8) : 5'(SPI_LEN16)));
  assign lane      = {{(WIDTH-8){~len8}}, 8'hFF};
  assign diff      = (shft ^ match) & ~mask & lane;
  assign frame_hit = armed & len_ok & (diff == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shft    <= '0;
      bit_cnt <= '0;
      SPItrig <= 1'b0;
    end else begin
      state   <= state_nxt;
      shft    <= shft_nxt;
      bit_cnt <= cnt_nxt;
      SPItrig <= trig_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    shft_nxt  = shft;
    cnt_nxt   = bit_cnt;
    trig_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        shft_nxt = '0;
        cnt_nxt  = '0;
        if (ss_fall) state_nxt = RX;
      end
      RX: begin
        // An SCLK edge landing with the SS_n rise belongs to no frame.
        if (ss_rise) begin
          state_nxt = CHECK;
        end else if (sclk_sel) begin
          shft_nxt = {shft[WIDTH-2:0], mosi_sync};
          if (bit_cnt != 5'd31) cnt_nxt = bit_cnt + 5'd1;
        end
      end
      CHECK: begin
        trig_nxt  = frame_hit;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef SPI_TRIG_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || !armed) begin
      frm_cnt <= '0;
    end else if (trig_nxt && (frm_cnt != 8'hFF)) begin
      frm_cnt <= frm_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_spi_prot_trig.sv
// Directed self-checking bench for spi_prot_trig; counter checks are built
// only when SPI_TRIG_CNT_EN is defined.
module tb_spi_prot_trig;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        pos_edge;
  logic        len8;
  logic [15:0] match;
  logic [15:0] mask;
  logic        armed;
  logic        SPItrig;
`ifdef SPI_TRIG_CNT_EN
  logic [7:0]  frm_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spi_prot_trig #(.WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .SS_n(SS_n),
    .SCLK(SCLK),
    .MOSI(MOSI),
    .pos_edge(pos_edge),
    .len8(len8),
    .match(match),
    .mask(mask),
    .armed(armed),
    .SPItrig(SPItrig)
`ifdef SPI_TRIG_CNT_EN
    ,
    .frm_cnt(frm_cnt)
`endif
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // rise_sample=1: MOSI launched on SCLK fall, valid at rise.
  // rise_sample=0: MOSI launched on SCLK rise, valid at fall.
  task automatic send_frame(input logic [15:0] val, input int nbits, input bit rise_sample,
                            input int rst_bit, input int disarm_bit);
    SS_n = 1'b0;
    tick(4);
    for (int k = 0; k < nbits; k++) begin
      if (k == rst_bit) begin
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
      end
      if (k == disarm_bit) armed = 1'b0;
      if (rise_sample) begin
        MOSI = val[nbits-1-k];
        tick(4);
        SCLK = 1'b1;
        tick(4);
        SCLK = 1'b0;
      end else begin
        SCLK = 1'b1;
        MOSI = val[nbits-1-k];
        tick(4);
        SCLK = 1'b0;
        tick(4);
      end
    end
    MOSI = 1'b0;
    tick(4);
    SS_n = 1'b1;
  endtask

  // The first posedge after SS_n rises samples it; the pulse belongs on the 4th.
  task automatic expect_trig(input bit exp, input string name);
    logic [5:0] seen;
    logic [5:0] want;
    seen = '0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      seen[k] = SPItrig;
    end
    want = exp ? 6'b001000 : 6'b000000;
    checks++;
    if (seen !== want) begin
      failures++;
      $display("FAIL %s: SPItrig over edges 6..1 = %b, expected %b", name, seen, want);
    end
  endtask

  task automatic frame(input logic [15:0] val, input int nbits, input bit rise_sample,
                       input bit exp, input string name);
    send_frame(val, nbits, rise_sample, -1, -1);
    expect_trig(exp, name);
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    SS_n     = 1'b1;
    SCLK     = 1'b0;
    MOSI     = 1'b0;
    pos_edge = 1'b0;
    len8     = 1'b0;
    match    = 16'hABCD;
    mask     = 16'h0000;
    armed    = 1'b1;
    tick(3);
    checks++;
    if (SPItrig !== 1'b0) begin
      failures++;
      $display("FAIL reset_trig: SPItrig = %b, expected 0", SPItrig);
    end
`ifdef SPI_TRIG_CNT_EN
    checks++;
    if (frm_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_cnt: frm_cnt = %0d, expected 0", frm_cnt);
    end
`endif
    rst = 1'b0;
    tick(4);
  endtask

  task automatic test_match16();
    match = 16'hABCD;
    mask  = 16'h0000;
    frame(16'hABCD, 16, 1'b0, 1'b1, "match16_exact");
    frame(16'hABCF, 16, 1'b0, 1'b0, "match16_diff");
    mask = 16'h000F;
    frame(16'hABCF, 16, 1'b0, 1'b1, "match16_masked");
    frame(16'h1BCF, 16, 1'b0, 1'b0, "match16_msb_diff");
    mask = 16'h0000;
  endtask

  task automatic test_len8();
    len8  = 1'b1;
    match = 16'h0096;
    mask  = 16'hFF00;
    frame(16'h0096, 8,  1'b0, 1'b1, "len8_byte");
    frame(16'h0096, 16, 1'b0, 1'b0, "len8_16bit_frame");
    frame(16'h0096, 7,  1'b0, 1'b0, "len8_short_frame");
    len8 = 1'b0;
    mask = 16'h0000;
  endtask

  task automatic test_pos_edge();
    match    = 16'h1234;
    pos_edge = 1'b1;
    frame(16'h1234, 16, 1'b1, 1'b1, "pos_edge_rise");
    pos_edge = 1'b0;
    frame(16'h1234, 16, 1'b1, 1'b0, "pos_edge_wrong_edge");
  endtask

  task automatic test_disarm();
    match = 16'hABCD;
    send_frame(16'hABCD, 16, 1'b0, -1, 5);
    expect_trig(1'b0, "disarm_mid_frame");
    armed = 1'b1;
    tick(2);
    frame(16'hABCD, 16, 1'b0, 1'b1, "rearmed");
  endtask

  task automatic test_rst_mid();
    match = 16'hABCD;
    send_frame(16'hABCD, 16, 1'b0, 7, -1);
    expect_trig(1'b0, "rst_mid_frame");
    frame(16'hABCD, 16, 1'b0, 1'b1, "after_rst_frame");
  endtask

  task automatic test_back_to_back();
    match = 16'hABCD;
    frame(16'hABCD, 16, 1'b0, 1'b1, "b2b_first");
    frame(16'hABCD, 16, 1'b0, 1'b1, "b2b_second");
    frame(16'hABCC, 16, 1'b0, 1'b0, "b2b_third_diff");
  endtask

  task automatic test_counter();
`ifdef SPI_TRIG_CNT_EN
    match = 16'hABCD;
    mask  = 16'h0000;
    armed = 1'b0;
    tick(2);
    armed = 1'b1;
    tick(2);
    frame(16'hABCD, 16, 1'b0, 1'b1, "cnt_hit1");
    frame(16'h1234, 16, 1'b0, 1'b0, "cnt_miss1");
    frame(16'hABCD, 16, 1'b0, 1'b1, "cnt_hit2");
    frame(16'hABC0, 16, 1'b0, 1'b0, "cnt_miss2");
    frame(16'hABCD, 16, 1'b0, 1'b1, "cnt_hit3");
    checks++;
    if (frm_cnt !== 8'd3) begin
      failures++;
      $display("FAIL cnt_three: frm_cnt = %0d, expected 3", frm_cnt);
    end
    armed = 1'b0;
    tick(2);
    checks++;
    if (frm_cnt !== 8'd0) begin
      failures++;
      $display("FAIL cnt_disarm_clear: frm_cnt = %0d, expected 0", frm_cnt);
    end
    armed = 1'b1;
    tick(2);
`endif
  endtask

  initial begin
    test_reset();
    test_match16();
    test_len8();
    test_pos_edge();
    test_disarm();
    test_rst_mid();
    test_back_to_back();
    test_counter();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
